// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit with HI/LO result registers.
// state | meaning: IDLE wait for start or MTHI/MTLO; RUN 32 iterations; FIX apply signs, write hi/lo
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    localparam logic [4:0] LAST_ITER = 5'd31;

    logic [1:0]  state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] mag_a_q, mag_a_d;
    logic [31:0] mag_b_q, mag_b_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        in_signed;
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    logic        is_div;
    logic        is_signed;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic [31:0] div_diff;
    logic        div_ge;
    logic [63:0] div_next;

    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] a_orig;

    always_comb begin
        in_signed = ~op[0];
        abs_a     = (in_signed && a[31]) ? (32'd0 - a) : a;
        abs_b     = (in_signed && b[31]) ? (32'd0 - b) : b;

        is_div    = op_q[1];
        is_signed = ~op_q[0];

        // Product register: upper half accumulates, multiplier shifts out of the bottom.
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_a_q} : 33'd0);
        mul_next  = {mul_sum, acc_q[31:1]};

        // Remainder in the upper half, dividend/quotient in the lower half.
        div_shift = {acc_q[63:32], acc_q[31]};
        div_ge    = (div_shift >= {1'b0, mag_b_q});
        div_diff  = div_shift[31:0] - mag_b_q;
        div_next  = div_ge ? {div_diff, acc_q[30:0], 1'b1}
                           : {div_shift[31:0], acc_q[30:0], 1'b0};

        prod_fix  = (is_signed && (sign_a_q ^ sign_b_q)) ? (64'd0 - acc_q) : acc_q;
        quo_fix   = (is_signed && (sign_a_q ^ sign_b_q)) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        rem_fix   = (is_signed && sign_a_q) ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
        a_orig    = (is_signed && sign_a_q) ? (32'd0 - mag_a_q) : mag_a_q;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    op_d     = op;
                    mag_a_d  = abs_a;
                    mag_b_d  = abs_b;
                    sign_a_d = a[31];
                    sign_b_d = b[31];
                    cnt_d    = 5'd0;
                    acc_d    = op[1] ? {32'd0, abs_a} : {32'd0, abs_b};
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = is_div ? div_next : mul_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_ITER) state_d = ST_FIX;
            end
            ST_FIX: begin
                if (!is_div) begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end else if (mag_b_q == 32'd0) begin
                    hi_d = a_orig;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= 2'd0;
            mag_a_q  <= 32'd0;
            mag_b_q  <= 32'd0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            cnt_q    <= 5'd0;
            acc_q    <= 64'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
